sha3_sponge_sequencer: RTL and testbench
========================================

Name: sha3_sponge_sequencer

Overview:
- Controls absorb and squeeze for one Keccak-f[1600] single-round datapath: the round function, the 1600-bit state register and the rate-sized XOR input.
- Accepts padded rate blocks from the padding stage and issues one round per enabled cycle, ROUNDS rounds per permutation.
- Runs extra permutations for multi-block (SHAKE/XOF) squeeze output, then clears the state for the next message.

Parameters:
R_BLOCK_SIZE, 1152, rate in bits. Informational only; selects no logic here; passed through for datapath consistency checks.
ROUNDS, 24, rounds per permutation; must be >= 2.
OBLK_W, 8, width of the squeeze block-count input.

Ports:
CLK  in  1  clock.
A_RST  in  1  reset; synchronous, active-high.
CE  in  1  clock enable. Low freezes all state; all pulse outputs are forced to 0.
BLK_VALID  in  1  padded rate block available from padding.
BLK_LAST  in  1  qualifies BLK_VALID: this is the final block of the message.
OUT_BLOCKS  in  OBLK_W  number of rate blocks to squeeze. Sampled when the last block is accepted; 0 is treated as 1.
BLK_READY  out  1  sequencer can accept a block this cycle.
ABSORB  out  1  datapath XORs the input block into state[0:R_BLOCK_SIZE-1] this cycle.
ROUND_EN  out  1  datapath registers the round output this cycle.
ROUND_IDX  out  $clog2(ROUNDS)  round-constant index for this cycle.
STATE_CLR  out  1  datapath zeroes its state register this cycle.
OUT_VALID  out  1  state rate portion is a valid output block.
OUT_READY  in  1  downstream accepts the output block.
OUT_LAST  out  1  qualifies OUT_VALID: this is the final squeeze block.
BUSY  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ROUNDS_RUN, SQUEEZE, CLEAR. All transitions occur only on CLK edges with CE=1.
- Reset (A_RST=1 at an edge): state goes to IDLE, round counter and squeeze counter go to 0, last-flag clears. While A_RST is high, all outputs are 0 (including BLK_READY). Reset mid-permutation or mid-squeeze aborts with no OUT_VALID; the datapath is reset by its own reset.
- IDLE:
  - BLK_READY = CE.
  - On BLK_VALID & BLK_READY in cycle t: ABSORB=1, ROUND_EN=1, ROUND_IDX=0 combinationally in cycle t (round 0 runs on XORed state); latch BLK_LAST.
  - If BLK_LAST: load squeeze counter = max(OUT_BLOCKS,1).
  - Next state: ROUNDS_RUN with round counter = 1.
- ROUNDS_RUN:
  - ROUND_EN=1, ROUND_IDX=counter, counter increments each cycle; BLK_READY=0; BLK_VALID is ignored.
  - In the cycle with ROUND_IDX=ROUNDS-1: next state is SQUEEZE if the last-flag is set, else IDLE.
  - Block accepted at t: rounds occupy t..t+ROUNDS-1; next block accepted no earlier than t+ROUNDS.
- SQUEEZE:
  - OUT_VALID=1; OUT_LAST = (squeeze counter == 1).
  - OUT_VALID, OUT_LAST and the state are held stable until OUT_READY. No ROUND_EN or ABSORB is issued here.
  - On handshake with counter==1: go to CLEAR.
  - On handshake with counter>1: decrement counter, go to ROUNDS_RUN with round counter = 0. ROUND_IDX=0 is issued in the next cycle with no ABSORB.
  - First OUT_VALID for the last input block appears at t+ROUNDS.
- CLEAR: STATE_CLR=1 for exactly one cycle; clear last-flag; next state is IDLE. BLK_READY=0 in CLEAR.
- CE=0 in any state: no transition, counters hold, ABSORB/ROUND_EN/STATE_CLR/BLK_READY are 0. OUT_VALID holds its value, but a handshake requires CE=1.
- ROUND_IDX is 0 whenever ROUND_EN=0.
- Counter width is $clog2(ROUNDS); no wrap occurs because the counter is reloaded before it exceeds ROUNDS-1.
- Simultaneous BLK_VALID and OUT_READY in SQUEEZE: only OUT_READY acts.

Test Plan:
- Reset then single last block: A_RST held 2 cycles, then BLK_VALID=BLK_LAST=1 with OUT_BLOCKS=1 at cycle 10 -> ABSORB=1 and ROUND_IDX=0 at cycle 10; ROUND_IDX 1..23 on cycles 11..33; OUT_VALID=OUT_LAST=1 at cycle 34; OUT_READY at 36 -> STATE_CLR at 37; BLK_READY=1 at 38.
- Two-block message: block A (last=0) at cycle 0 -> BLK_READY=0 for cycles 1..23, =1 at 24; block B (last=1) at 24 -> OUT_VALID at 48. Exactly two ABSORB pulses total.
- XOF OUT_BLOCKS=3: OUT_READY tied high -> three OUT_VALID beats, each separated by 24 ROUND_EN cycles with ABSORB=0; OUT_LAST only on the third beat; one STATE_CLR. OUT_BLOCKS=0 behaves identically to OUT_BLOCKS=1.
- Backpressure: OUT_READY low for 5 cycles in SQUEEZE -> OUT_VALID and OUT_LAST stable, ROUND_EN=0, BLK_VALID ignored throughout.
- CE gating: CE=0 for 3 cycles at ROUND_IDX=7 -> ROUND_EN=0 during the gap; the run resumes at ROUND_IDX=8 and the total number of ROUND_EN cycles is still 24.
- Mid-operation reset: A_RST at ROUND_IDX=12 -> next cycle is IDLE with all outputs 0; after release, BLK_READY=1 and OUT_VALID never asserts for the aborted message.

Source files
------------

// File: rtl/sha3_sponge_sequencer.sv
// Absorb/squeeze sequencer for a single-round-per-cycle Keccak-f[1600] datapath.
// Issues per-cycle round enables, block XOR strobes, squeeze handshakes and state clears.
module sha3_sponge_sequencer #(
  parameter int R_BLOCK_SIZE = 1152,
  parameter int ROUNDS       = 24,
  parameter int OBLK_W       = 8
) (
  input  logic                      CLK,
  input  logic                      A_RST,
  input  logic                      CE,
  input  logic                      BLK_VALID,
  input  logic                      BLK_LAST,
  input  logic [OBLK_W-1:0]         OUT_BLOCKS,
  output logic                      BLK_READY,
  output logic                      ABSORB,
  output logic                      ROUND_EN,
  output logic [$clog2(ROUNDS)-1:0] ROUND_IDX,
  output logic                      STATE_CLR,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      OUT_LAST,
  output logic                      BUSY
);

  localparam int            CW       = $clog2(ROUNDS);
  localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUNDS_RUN,
    S_SQUEEZE,
    S_CLEAR
  } state_t;

  // The rate is only carried for datapath consistency; reject impossible values early.
  if (ROUNDS < 2) begin : g_bad_rounds
    $error("sha3_sponge_sequencer: ROUNDS must be >= 2");
  end
  if (R_BLOCK_SIZE <= 0 || R_BLOCK_SIZE >= 1600) begin : g_bad_rate
    $error("sha3_sponge_sequencer: R_BLOCK_SIZE must lie in 1..1599");
  end

  state_t              state_q, state_d;
  logic [CW-1:0]       rnd_q, rnd_d;
  logic [OBLK_W-1:0]   sq_q, sq_d;
  logic                last_q, last_d;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    sq_d      = sq_q;
    last_d    = last_q;
    BLK_READY = 1'b0;
    ABSORB    = 1'b0;
    ROUND_EN  = 1'b0;
    ROUND_IDX = '0;
    STATE_CLR = 1'b0;
    OUT_VALID = 1'b0;
    OUT_LAST  = 1'b0;
    BUSY      = 1'b0;

    if (!A_RST) begin
      BUSY = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          BLK_READY = CE;
          if (CE && BLK_VALID) begin
            // Round 0 runs in the accept cycle on the freshly XORed state.
            ABSORB   = 1'b1;
            ROUND_EN = 1'b1;
            last_d   = BLK_LAST;
            if (BLK_LAST) begin
              sq_d = (OUT_BLOCKS == '0) ? OBLK_W'(1) : OUT_BLOCKS;
            end
            rnd_d   = CW'(1);
            state_d = S_ROUNDS_RUN;
          end
        end

        S_ROUNDS_RUN: begin
          if (CE) begin
            ROUND_EN  = 1'b1;
            ROUND_IDX = rnd_q;
            if (rnd_q == LAST_RND) begin
              rnd_d   = '0;
              state_d = last_q ? S_SQUEEZE : S_IDLE;
            end else begin
              rnd_d = rnd_q + CW'(1);
            end
          end
        end

        S_SQUEEZE: begin
          OUT_VALID = 1'b1;
          OUT_LAST  = (sq_q == OBLK_W'(1));
          if (CE && OUT_READY) begin
            if (OUT_LAST) begin
              state_d = S_CLEAR;
            end else begin
              // Another XOF block needs a bare permutation: no absorb, round 0 next cycle.
              sq_d    = sq_q - OBLK_W'(1);
              rnd_d   = '0;
              state_d = S_ROUNDS_RUN;
            end
          end
        end

        S_CLEAR: begin
          if (CE) begin
            STATE_CLR = 1'b1;
            last_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge CLK) begin
    if (A_RST) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      sq_q    <= '0;
      last_q  <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      sq_q    <= sq_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sha3_sponge_sequencer.sv
// Self-checking bench: directed timing scenarios plus random stimulus, compared
// every cycle against a work-remaining model of the sponge schedule.
module tb_sha3_sponge_sequencer;

  localparam int ROUNDS = 24;
  localparam int OBLK_W = 8;
  localparam int CW     = $clog2(ROUNDS);

  logic              CLK = 1'b0;
  logic              A_RST, CE, BLK_VALID, BLK_LAST, OUT_READY;
  logic [OBLK_W-1:0] OUT_BLOCKS;
  logic              BLK_READY, ABSORB, ROUND_EN, STATE_CLR, OUT_VALID, OUT_LAST, BUSY;
  logic [CW-1:0]     ROUND_IDX;

  sha3_sponge_sequencer #(
    .R_BLOCK_SIZE(1152),
    .ROUNDS      (ROUNDS),
    .OBLK_W      (OBLK_W)
  ) dut (
    .CLK       (CLK),
    .A_RST     (A_RST),
    .CE        (CE),
    .BLK_VALID (BLK_VALID),
    .BLK_LAST  (BLK_LAST),
    .OUT_BLOCKS(OUT_BLOCKS),
    .BLK_READY (BLK_READY),
    .ABSORB    (ABSORB),
    .ROUND_EN  (ROUND_EN),
    .ROUND_IDX (ROUND_IDX),
    .STATE_CLR (STATE_CLR),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_LAST  (OUT_LAST),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Model: how much work is still owed, not which state the controller is in.
  int m_rounds_left;   // enabled round cycles left in the current permutation
  int m_outs_left;     // output blocks still owed for the message
  bit m_out_pend;      // an output block is on offer
  bit m_clr_pend;      // a state clear is owed
  bit m_last;          // the absorbed message is complete

  function automatic bit m_idle();
    return (m_rounds_left == 0) && !m_out_pend && !m_clr_pend;
  endfunction

  function automatic logic [11:0] model_expect();
    logic ready, absorb, ren, clr, ov, ol, busy;
    logic [CW-1:0] idx;
    if (A_RST) return '0;
    ready  = CE && m_idle();
    absorb = ready && BLK_VALID;
    ren    = CE && (m_rounds_left > 0 || absorb);
    idx    = (ren && !absorb) ? CW'(ROUNDS - m_rounds_left) : '0;
    clr    = CE && m_clr_pend;
    ov     = m_out_pend;
    ol     = m_out_pend && (m_outs_left == 1);
    busy   = !m_idle();
    return {ready, absorb, ren, idx, clr, ov, ol, busy};
  endfunction

  task automatic model_step();
    if (A_RST) begin
      m_rounds_left = 0; m_outs_left = 0; m_out_pend = 0; m_clr_pend = 0; m_last = 0;
    end else if (CE) begin
      if (m_idle() && BLK_VALID) begin
        m_rounds_left = ROUNDS - 1;
        m_last        = BLK_LAST;
        if (BLK_LAST) m_outs_left = (OUT_BLOCKS == 0) ? 1 : int'(OUT_BLOCKS);
      end else if (m_rounds_left > 0) begin
        m_rounds_left--;
        if (m_rounds_left == 0 && m_last) m_out_pend = 1;
      end else if (m_out_pend) begin
        if (OUT_READY) begin
          m_out_pend = 0;
          if (m_outs_left == 1) begin
            m_clr_pend = 1;
          end else begin
            m_outs_left--;
            m_rounds_left = ROUNDS;
          end
        end
      end else if (m_clr_pend) begin
        m_clr_pend = 0;
        m_last     = 0;
      end
    end
  endtask

  logic          s_ready, s_absorb, s_ren, s_clr, s_ov, s_ol, s_busy;
  logic [CW-1:0] s_idx;
  logic [11:0]   snap;
  int n_absorb = 0, n_ren = 0, n_beats = 0, n_last_beats = 0, n_clr = 0, n_ov = 0;

  // One clock cycle: drive on the falling edge, sample 1 ns later, compare, advance model.
  task automatic tick(input logic ce, input logic bv, input logic bl,
                      input logic [OBLK_W-1:0] ob, input logic ordy, input logic rst);
    @(negedge CLK);
    CE = ce; BLK_VALID = bv; BLK_LAST = bl; OUT_BLOCKS = ob; OUT_READY = ordy; A_RST = rst;
    #1;
    s_ready = BLK_READY; s_absorb = ABSORB; s_ren = ROUND_EN; s_idx = ROUND_IDX;
    s_clr = STATE_CLR; s_ov = OUT_VALID; s_ol = OUT_LAST; s_busy = BUSY;
    snap = {s_ready, s_absorb, s_ren, s_idx, s_clr, s_ov, s_ol, s_busy};
    check("outputs", 32'(snap), 32'(model_expect()));
    n_absorb += int'(s_absorb);
    n_ren    += int'(s_ren);
    n_clr    += int'(s_clr);
    n_ov     += int'(s_ov);
    if (ce && s_ov && ordy) begin
      n_beats++;
      if (s_ol) n_last_beats++;
    end
    model_step();
    cyc++;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (s_ov) break;
      tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    if (!s_ov) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idx(input logic [CW-1:0] idx, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (s_ren && s_idx == idx) break;
      tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    end
    if (!(s_ren && s_idx == idx)) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic finish_msg();
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_xof(input logic [OBLK_W-1:0] ob, input int exp_beats, input string tag);
    int b_beats, b_last, b_ren, b_abs, b_clr;
    b_beats = n_beats; b_last = n_last_beats; b_ren = n_ren; b_abs = n_absorb; b_clr = n_clr;
    tick(1'b1, 1'b1, 1'b1, ob, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (n_clr != b_clr) break;
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    check({tag, "_beats"},      32'(n_beats - b_beats),     32'(exp_beats));
    check({tag, "_last_beats"}, 32'(n_last_beats - b_last), 32'd1);
    check({tag, "_round_en"},   32'(n_ren - b_ren),         32'(exp_beats * ROUNDS));
    check({tag, "_absorbs"},    32'(n_absorb - b_abs),      32'd1);
    check({tag, "_clears"},     32'(n_clr - b_clr),         32'd1);
  endtask

  initial begin
    int t_a, t_b, base;
    A_RST = 1'b1; CE = 1'b1; BLK_VALID = 1'b0; BLK_LAST = 1'b0; OUT_BLOCKS = '0; OUT_READY = 1'b0;
    m_rounds_left = 0; m_outs_left = 0; m_out_pend = 0; m_clr_pend = 0; m_last = 0;

    // Reset, then one final block with a single output block.
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
    check("reset_all_zero", 32'(snap), 32'd0);
    repeat (8) tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("idle_ready", 32'(s_ready), 32'd1);
    tick(1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    t_a = cyc - 1;
    check("absorb_round0", 32'({s_absorb, s_ren, s_idx}), 32'({1'b1, 1'b1, CW'(0)}));
    wait_out("single");
    check("single_out_latency", 32'(cyc - 1 - t_a), 32'(ROUNDS));
    check("single_out_last", 32'(s_ol), 32'd1);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("state_clr_pulse", 32'(s_clr), 32'd1);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("ready_after_clear", 32'(s_ready), 32'd1);

    // Two-block message with BLK_VALID held high.
    base = n_absorb;
    tick(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    t_a = cyc - 1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
      if (s_ready) break;
    end
    t_b = cyc - 1;
    check("second_block_gap", 32'(t_b - t_a), 32'(ROUNDS));
    wait_out("two_block");
    check("two_block_latency", 32'(cyc - 1 - t_b), 32'(ROUNDS));
    check("two_block_absorbs", 32'(n_absorb - base), 32'd2);
    finish_msg();

    // XOF squeeze, and OUT_BLOCKS=0 behaving as 1.
    run_xof(8'd3, 3, "xof3");
    run_xof(8'd0, 1, "xof0");

    // Backpressure with competing block offers.
    tick(1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    wait_out("bp");
    base = n_absorb;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
      check("bp_hold", 32'({s_ov, s_ol, s_ren, s_ready}), 32'({1'b1, 1'b1, 1'b0, 1'b0}));
    end
    check("bp_no_absorb", 32'(n_absorb - base), 32'd0);
    finish_msg();

    // Clock-enable gap in the middle of a permutation.
    base = n_ren;
    tick(1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    wait_idx(CW'(7), "ce_gap");
    repeat (3) begin
      tick(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("ce_gap_quiet", 32'({s_ren, s_idx, s_ready}), 32'd0);
    end
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("ce_gap_resume_idx", 32'(s_idx), 32'd8);
    wait_out("ce_gap");
    check("ce_gap_round_total", 32'(n_ren - base), 32'(ROUNDS));
    finish_msg();

    // Reset in the middle of a permutation aborts the message.
    tick(1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
    wait_idx(CW'(12), "abort");
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("abort_rst_zero", 32'(snap), 32'd0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("abort_idle", 32'({s_ready, s_busy}), 32'({1'b1, 1'b0}));
    base = n_ov;
    repeat (40) tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("abort_no_output", 32'(n_ov - base), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(9) != 0), $urandom_range(1) == 1, $urandom_range(1) == 1,
           OBLK_W'($urandom_range(3)), $urandom_range(4) < 3, $urandom_range(399) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
